// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between the fetch (inst) and load/store (data)
// requesters, generates byte strobes and routes each 1-cycle-latency response to its owner.
module sram_port_arbiter #(
  parameter int unsigned PRIO_MODE    = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  logic             r_resp_v;
  owner_e           r_resp_owner;
  owner_e           r_rr_last;
  logic [CNT_W-1:0] r_starve_cnt;

  logic             w_gnt_inst;
  logic             w_gnt_data;
  logic             w_starved;

  // Misaligned half/word and size 3 yield no strobes: the write is dropped but still acked.
  function automatic logic [3:0] strobe(input logic wr, input logic [1:0] size,
                                        input logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    if (wr) begin
      case (size)
        2'd0:    s = 4'b0001 << a;
        2'd1:    if (!a[0]) s = 4'b0011 << a;
        2'd2:    if (a == 2'd0) s = 4'b1111;
        default: s = 4'b0000;
      endcase
    end
    return s;
  endfunction

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Grant: data-priority with starvation guard, or round-robin on conflict.
  always_comb begin
    w_gnt_inst = 1'b0;
    w_gnt_data = 1'b0;
    if (!reset) begin
      if (PRIO_MODE == 0) begin
        w_gnt_inst = inst_req & (!data_req | w_starved);
      end else begin
        w_gnt_inst = inst_req & (!data_req | (r_rr_last == OWN_DATA));
      end
      w_gnt_data = data_req & !w_gnt_inst;
    end
  end

  always_comb begin
    sram_wen   = 4'b0000;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    if (w_gnt_inst) begin
      sram_wen   = strobe(inst_wr, inst_size, inst_addr[1:0]);
      sram_addr  = {inst_addr[31:2], 2'b00};
      sram_wdata = inst_wdata;
    end else if (w_gnt_data) begin
      sram_wen   = strobe(data_wr, data_size, data_addr[1:0]);
      sram_addr  = {data_addr[31:2], 2'b00};
      sram_wdata = data_wdata;
    end
  end

  assign sram_en      = w_gnt_inst | w_gnt_data;
  assign inst_addr_ok = w_gnt_inst;
  assign data_addr_ok = w_gnt_data;

  assign inst_data_ok = r_resp_v & (r_resp_owner == OWN_INST);
  assign data_data_ok = r_resp_v & (r_resp_owner == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? sram_rdata : 32'h0;

  // Response tag, round-robin pointer and fetch starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_v     <= 1'b0;
      r_resp_owner <= OWN_INST;
      r_rr_last    <= OWN_DATA;
      r_starve_cnt <= '0;
    end else begin
      r_resp_v     <= sram_en;
      r_resp_owner <= owner_e'(w_gnt_data);
      if (sram_en) begin
        r_rr_last <= owner_e'(w_gnt_data);
      end
      if (w_gnt_inst || !inst_req) begin
        r_starve_cnt <= '0;
      end else if (PRIO_MODE == 0 && data_req && w_gnt_data) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch requester (inst_*) and the load/store requester (data_*).
- Uses a req/addr_ok/data_ok handshake on both sides and issues at most one SRAM access per cycle.
- Tags each issued access and routes the one-cycle-later read data back to its owner.
- Generates byte write strobes from size/address, and bounds fetch starvation under data-priority arbitration.

Parameters:
- PRIO_MODE, 0, arbitration policy: 0 = fixed data priority with starvation guard; 1 = round-robin.
- STARVE_LIMIT, 4, in PRIO_MODE 0: number of consecutive cycles inst may lose arbitration; after that it gets forced priority.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request valid
- inst_wr  in  1  fetch write flag; 1 = write (normally 0)
- inst_size  in  2  access size: 0 = byte, 1 = half, 2 = word
- inst_addr  in  32  byte address
- inst_wdata  in  32  write data, already lane-aligned by the requester
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  response valid
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  same meanings as the inst_* inputs, for the data requester
- data_addr_ok, data_data_ok, data_rdata  out  1/1/32  same meanings as the inst_* outputs, for the data requester
- sram_en  out  1  SRAM access enable
- sram_wen  out  4  byte write strobes
- sram_addr  out  32  word-aligned address: {addr[31:2], 2'b00}
- sram_wdata  out  32  write data
- sram_rdata  in  32  SRAM read data, valid the cycle after the access

Behaviour:
- **Timing.** SRAM read latency is exactly 1 cycle. Throughput is one grant per cycle with no bubbles. Requesters must accept data_ok unconditionally; there is no response backpressure.
- **Grant.** Combinational and same-cycle.
  - gnt_inst/gnt_data are mutually exclusive.
  - x_addr_ok = gnt_x. sram_en = gnt_inst | gnt_data.
  - sram_addr, sram_wdata and sram_wen come from the granted requester. They are 0 when nothing is granted.
- **PRIO_MODE 0.**
  - Data wins by default.
  - starve_cnt (3 bits) increments when inst_req & data_req & gnt_data.
  - starve_cnt clears when gnt_inst or !inst_req.
  - When starve_cnt == STARVE_LIMIT and inst_req, inst wins this cycle and the counter clears.
- **PRIO_MODE 1.**
  - rr_last register holds the last granted requester (0 = inst, 1 = data); on conflict the other requester wins.
  - rr_last updates only on a grant.
  - A lone requester always wins.
- **Write strobes.** Let a = addr[1:0]. sram_wen = 0 for reads.
  - Byte: 4'b0001 << a.
  - Half: 4'b0011 << a when a[0]==0.
  - Word: 4'b1111 when a==0.
  - Misaligned half/word, or size==3: sram_wen = 4'b0000. The write is dropped but still acknowledged (addr_ok then data_ok).
- **Response tracking.**
  - resp_v and resp_owner are registered on any grant: resp_v <= sram_en, resp_owner <= gnt_data.
  - The next cycle, x_data_ok = resp_v & (resp_owner==x).
  - x_rdata = sram_rdata when x_data_ok, otherwise 0.
  - Writes also produce data_ok; rdata is don't-care for writes.
- **Simultaneous events.** A new grant and the response of the previous grant occur in the same cycle independently. The same requester can see addr_ok and data_ok together.
- **Reset (asynchronous).**
  - Clears resp_v, resp_owner, starve_cnt and rr_last; rr_last resets to 1, so inst wins the first conflict in PRIO_MODE 1.
  - While reset is high, all grants are forced to 0.
  - Outputs during reset: addr_ok = 0, data_ok = 0, sram_en = 0, sram_wen = 0, sram_addr = 0, sram_wdata = 0, rdata = 0.
  - Reset mid-transaction discards the pending response; no data_ok follows deassertion.

Test Plan:
1. **Lone inst read.** inst_req=1, inst_addr=0x1FC0_0004, size=2.
   - Same cycle: inst_addr_ok=1, sram_en=1, sram_wen=0, sram_addr=0x1FC0_0004.
   - Next cycle, with sram_rdata=0x2408_0001: inst_data_ok=1, inst_rdata=0x2408_0001, data_data_ok=0.
2. **Byte and half store strobes.**
   - data_wr=1, size=0, addr=0x8000_0003 -> sram_wen=4'b1000, sram_addr=0x8000_0000; data_data_ok next cycle.
   - size=1, addr=0x8000_0002 -> wen=4'b1100.
   - size=1, addr=0x8000_0001 -> wen=4'b0000, data_addr_ok=1.
3. **Starvation guard, PRIO_MODE 0, STARVE_LIMIT=4.** Both requesting continuously.
   - Grants: data, data, data, data, inst, data×4, inst...
   - starve_cnt reaches 4 exactly in the inst-grant cycles.
4. **Round-robin, PRIO_MODE 1.** Both requesting continuously from reset.
   - Grants alternate inst, data, inst, data.
   - Each data_ok routes to the correct owner with the sram_rdata value of that cycle.
5. **Back-to-back pipelining.** inst reads 0x0, 0x4, 0x8 on consecutive cycles.
   - addr_ok=1 in cycles 0–2; inst_data_ok=1 in cycles 1–3 with matching rdata; no bubbles.
6. **Reset mid-op.** Assert reset between a data grant and its response.
   - data_data_ok stays 0, all outputs go to 0 asynchronously.
   - After release, the first PRIO_MODE 1 conflict grants inst.
